// File: rtl/stored_code_register_pkg.sv
// Shared passcode constants and the digit-scramble order used by both the
// code register and the comparator, so both sides permute digits identically.
`ifndef PASSCODE
`define PASSCODE 16'h9070
`endif
`ifndef STORED_MASK
`define STORED_MASK 16'h2130
`endif

package stored_code_register_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int CODE_W     = DIGIT_W * NUM_DIGITS;

    localparam logic [CODE_W-1:0] DEFAULT_PASSCODE = `PASSCODE;
    localparam logic [CODE_W-1:0] DEFAULT_MASK     = `STORED_MASK;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Two bits per output slot, MSB slot first: output slot k takes input digit
    // SCRAMBLE_ORDER[2k+1:2k], giving {D2, D1, D3, D0}.
    localparam logic [2*NUM_DIGITS-1:0] SCRAMBLE_ORDER = {2'd2, 2'd1, 2'd3, 2'd0};

    function automatic logic [CODE_W-1:0] scramble_digits(input logic [CODE_W-1:0] plain);
        logic [CODE_W-1:0] result;
        logic [1:0]        srcIdx;
        result = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            srcIdx = SCRAMBLE_ORDER[2*k +: 2];
            result[DIGIT_W*k +: DIGIT_W] = plain[DIGIT_W*int'(srcIdx) +: DIGIT_W];
        end
        return result;
    endfunction

endpackage

// File: rtl/stored_code_register_code_scrambler.sv
// Combinational unmask-and-permute: removes the storage mask and reorders the
// digits into the comparator-side scrambled order.
module code_scrambler
    import stored_code_register_pkg::*;
#(
    parameter logic [CODE_W-1:0] MASK = DEFAULT_MASK
) (
    input  logic [CODE_W-1:0] masked_i,
    output logic [CODE_W-1:0] scrambled_o
);

    logic [CODE_W-1:0] plain;

    assign plain       = masked_i ^ MASK;
    assign scrambled_o = scramble_digits(plain);

endmodule

// File: rtl/stored_code_register.sv
// Passcode storage: holds the code XOR-masked in flops and presents it
// unmasked in scrambled digit order.
module stored_code_register
    import stored_code_register_pkg::*;
#(
    parameter logic [CODE_W-1:0] PASSCODE    = DEFAULT_PASSCODE,
    parameter logic [CODE_W-1:0] STORED_MASK = DEFAULT_MASK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CODE_W-1:0] datain,
    output logic [CODE_W-1:0] dataout
);

    localparam logic [CODE_W-1:0] RESET_STORED = PASSCODE ^ STORED_MASK;

    logic [CODE_W-1:0] stored_q;
    logic [CODE_W-1:0] stored_d;

    // The plaintext code is only ever formed combinationally; flops see it masked.
    always_comb begin
        stored_d = stored_q;
        if (load) begin
            stored_d = datain ^ STORED_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored_q <= RESET_STORED;
        end else begin
            stored_q <= stored_d;
        end
    end

    code_scrambler #(
        .MASK(STORED_MASK)
    ) u_scrambler (
        .masked_i   (stored_q),
        .scrambled_o(dataout)
    );

endmodule

// File: tb/tb_stored_code_register.sv
// Self-checking bench for stored_code_register: table-driven loads/holds through
// a scoreboard queue, plus hand-written reset and storage-masking sequences.
module tb_stored_code_register;

    typedef struct {
        logic        load;
        logic [15:0] data;
        logic [15:0] expOut;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] datain;
    logic [15:0] dataout;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] expQ[$];
    vec_t        vecs[$];

    stored_code_register dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .datain (datain),
        .dataout(dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(input logic l, input logic [15:0] d,
                                   input logic [15:0] e, input string n);
        vec_t v;
        v.load   = l;
        v.data   = d;
        v.expOut = e;
        v.name   = n;
        vecs.push_back(v);
    endfunction

    // Pops the oldest expectation and compares it against the current output.
    task automatic checkOutput(input string name);
        logic [15:0] exp;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, dataout=%h", name, dataout);
        end else begin
            exp = expQ.pop_front();
            if (dataout !== exp) begin
                errors++;
                $display("[TB] FAIL %s: dataout=%h expected=%h", name, dataout, exp);
            end
        end
    endtask

    task automatic checkStored(input string name, input logic [15:0] exp);
        checks++;
        if (dut.stored_q !== exp) begin
            errors++;
            $display("[TB] FAIL %s: stored_q=%h expected=%h", name, dut.stored_q, exp);
        end
    endtask

    // Drives one cycle of stimulus away from the active edge, then checks after it.
    task automatic applyStimulus(input logic l, input logic [15:0] d,
                                 input logic [15:0] e, input string name);
        @(negedge clk);
        load   = l;
        datain = d;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    initial begin
        rst_n  = 1'b1;
        load   = 1'b0;
        datain = 16'h0000;

        addVec(1'b1, 16'h1234, 16'h2314, "load_1234");
        addVec(1'b0, 16'hFFFF, 16'h2314, "hold_ffff");
        addVec(1'b0, 16'hABCD, 16'h2314, "hold_abcd");
        addVec(1'b1, 16'h4321, 16'h3241, "b2b_4321");
        addVec(1'b1, 16'h8765, 16'h7685, "b2b_8765");
        addVec(1'b1, 16'hABCD, 16'hBCAD, "load_abcd");
        addVec(1'b0, 16'h1111, 16'hBCAD, "hold_1111");
        addVec(1'b1, 16'h9070, 16'h0790, "load_default");
        addVec(1'b1, 16'h0F0F, 16'hF00F, "load_0f0f");

        // Asynchronous reset pulse with inputs idle.
        #1 rst_n = 1'b0;
        #10;
        expQ.push_back(16'h0790);
        checkOutput("reset_value");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expQ.push_back(16'h0790);
        checkOutput("after_release");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].load, vecs[i].data, vecs[i].expOut, vecs[i].name);
        end

        // Single load followed by a long hold with a toggling datain.
        applyStimulus(1'b1, 16'h1234, 16'h2314, "reload_1234");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, (i % 2 == 0) ? 16'hFFFF : 16'hABCD, 16'h2314, "hold_long");
        end

        // Reset asserted between edges during a load cycle: must win immediately.
        @(negedge clk);
        load   = 1'b1;
        datain = 16'h5555;
        #2 rst_n = 1'b0;
        #1;
        expQ.push_back(16'h0790);
        checkOutput("async_reset_no_edge");
        checkStored("async_reset_stored", 16'hB140);
        repeat (2) @(posedge clk);
        #1;
        expQ.push_back(16'h0790);
        checkOutput("reset_held_with_load");

        // Release mid-cycle with load high: the next edge performs the load.
        @(negedge clk);
        datain = 16'h1234;
        rst_n  = 1'b1;
        #1;
        expQ.push_back(16'h0790);
        checkOutput("release_no_edge_yet");
        @(posedge clk);
        #1;
        expQ.push_back(16'h2314);
        checkOutput("first_load_after_release");

        // Extreme codes and the masked storage contents behind them.
        applyStimulus(1'b1, 16'h0000, 16'h0000, "load_zero");
        checkStored("stored_zero", 16'h2130);
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, "load_ones");
        checkStored("stored_ones", 16'hDECF);
        applyStimulus(1'b0, 16'h0000, 16'hFFFF, "hold_ones");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/stored_code_register.md
Name: stored_code_register

Overview:
- Holds the safe's 4-digit BCD/hex passcode (four 4-bit digits D3..D0) in masked, obfuscated form.
- Presents the code to the comparator side in a fixed scrambled digit order.
- Resets asynchronously to the build-time default passcode.
- Can be reprogrammed with a synchronous load strobe.

Parameters:
- PASSCODE, 16'h9070, default code loaded at reset; digits {D3,D2,D1,D0}. Sourced from the shared `PASSCODE define.
- STORED_MASK, 16'h2130, XOR mask applied to the code while it sits in the storage flops. Sourced from the shared `STORED_MASK define.

Ports:
- clk  input  1  system clock; rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  synchronous write enable for a new code
- datain  input  16  new plaintext code, natural order {D3,D2,D1,D0}, D3 = datain[15:12]
- dataout  output  16  scrambled plaintext code, order {D2,D1,D3,D0}

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Storage: 16-bit register stored_q always holds (code XOR STORED_MASK). The plaintext code is never held in flops.
- Reset: when rst_n falls, stored_q <= PASSCODE ^ STORED_MASK (16'hB140 with defaults) immediately, without waiting for a clock edge.
  - dataout becomes 16'h0790 with defaults.
  - While rst_n = 0, stored_q is held and load is ignored.
- Load: on a clk rising edge with rst_n = 1 and load = 1, stored_q <= datain ^ STORED_MASK.
  - The new dataout is visible after that edge: one-cycle latency, no handshake.
  - load = 1 for consecutive cycles: last sampled datain wins.
- Hold: load = 0 leaves stored_q unchanged indefinitely.
- Output path is purely combinational from stored_q:
  - plain = stored_q ^ STORED_MASK, split into nibbles D3 = plain[15:12], D2 = [11:8], D1 = [7:4], D0 = [3:0]
  - dataout = {D2, D1, D3, D0}
  - dataout changes only after a reset assertion or a clock edge; it never glitches from datain.
- Reset released mid-cycle: the first load is sampled at the first rising edge after rst_n goes high.
- Reset asserted during a load cycle: reset wins; stored_q returns to the default.
- No X propagation: all 16 storage bits are reset.

Decomposition:
- Shared package/defines file holds:
  - `PASSCODE and `STORED_MASK
  - digit width (4) and digit count (4) constants
  - the digit-permutation order, reused by the comparator so user entries are scrambled identically
- Natural sub-module: code_scrambler, a combinational block that unmasks and permutes 16 bits → 16 bits. The comparator also instantiates it.
- The register itself stays in stored_code_register.

Test Plan:
1. Assert rst_n = 0 for 10 ns with load = 0, datain = 0, then release → dataout = 16'h0790 before any load.
2. After reset, load = 1, datain = 16'h1234 for one edge, then load = 0 → dataout = 16'h2314 on the following cycle and held for ≥5 cycles.
3. load = 0 while datain toggles (16'hFFFF, 16'hABCD) → dataout stays at the last loaded value.
4. Back-to-back loads of 16'h4321 then 16'h8765 → dataout = 16'h3241, then 16'h7685, each one edge after its load.
5. Assert rst_n low asynchronously between clock edges while load = 1, datain = 16'h5555 → dataout returns to 16'h0790 without a clock edge and stays there until release.
6. Load 16'h0000 and 16'hFFFF → dataout = 16'h0000 and 16'hFFFF; confirm via hierarchy that the internal stored_q equals 16'h2130 and 16'hDECF (mask applied).
